// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the key/config logic and the DDS sweep controller.
// master = configuration/key side, slave = sweep controller.
interface dds_sweep_ctrl_if #(
    parameter int FW_W    = 32,
    parameter int DWELL_W = 24
);
    logic               start;
    logic               abort;
    logic [1:0]         mode;
    logic [FW_W-1:0]    f_start;
    logic [FW_W-1:0]    f_stop;
    logic [FW_W-1:0]    f_step;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         wave_key;

    logic [FW_W-1:0]    freq_word;
    logic               word_upd;
    logic [3:0]         wave_sel;
    logic               busy;
    logic               done;
    logic               cfg_err;

    modport master (
        output start, abort, mode, f_start, f_stop, f_step, dwell, wave_key,
        input  freq_word, word_upd, wave_sel, busy, done, cfg_err
    );

    modport slave (
        input  start, abort, mode, f_start, f_stop, f_step, dwell, wave_key,
        output freq_word, word_upd, wave_sel, busy, done, cfg_err
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer for the DDS phase accumulator, plus the
// one-hot waveform select register fed by debounced key pulses.
module dds_sweep_ctrl #(
    parameter int FW_W    = 32,
    parameter int DWELL_W = 24
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    dds_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_STEP
    } state_e;

    typedef enum logic [1:0] {
        M_SINGLE = 2'b00,
        M_ROUND  = 2'b01,
        M_TRI    = 2'b10,
        M_SAW    = 2'b11
    } mode_e;

    state_e             state;
    mode_e              mode_q;
    logic [FW_W-1:0]    f_start_q;
    logic [FW_W-1:0]    f_stop_q;
    logic [FW_W-1:0]    f_step_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic               dir_up;
    // second_leg=0: heading for f_stop; second_leg=1: heading back to f_start
    logic               second_leg;

    logic [FW_W-1:0]    freq_word_q;
    logic               word_upd_q;
    logic [3:0]         wave_sel_q;
    logic               busy_q;
    logic               done_q;
    logic               cfg_err_q;

    logic [DWELL_W-1:0] dwell_eff;
    logic [FW_W-1:0]    target;
    logic [FW_W-1:0]    rev_target;
    logic [FW_W-1:0]    fwd_word;
    logic [FW_W-1:0]    rev_word;
    logic               at_target;

    // One step toward tgt, evaluated one bit wider so it cannot wrap;
    // the result saturates exactly on tgt.
    function automatic logic [FW_W-1:0] step_toward(
        input logic [FW_W-1:0] cur,
        input logic [FW_W-1:0] step,
        input logic [FW_W-1:0] tgt,
        input logic            up
    );
        logic [FW_W:0] wide;
        if (up) begin
            wide = {1'b0, cur} + {1'b0, step};
            return (wide >= {1'b0, tgt}) ? tgt : wide[FW_W-1:0];
        end else begin
            wide = {1'b0, cur} - {1'b0, step};
            return (wide[FW_W] || (wide[FW_W-1:0] <= tgt)) ? tgt : wide[FW_W-1:0];
        end
    endfunction

    // NOTE: every signal written here gets a value on every path (defaults
    // first), so no latch is inferred.
    always_comb begin
        dwell_eff  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
        target     = second_leg ? f_start_q : f_stop_q;
        rev_target = second_leg ? f_stop_q : f_start_q;
        at_target  = (freq_word_q == target);
        fwd_word   = step_toward(freq_word_q, f_step_q, target, dir_up);
        rev_word   = step_toward(freq_word_q, f_step_q, rev_target, ~dir_up);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            mode_q      <= M_SINGLE;
            f_start_q   <= '0;
            f_stop_q    <= '0;
            f_step_q    <= '0;
            dwell_q     <= DWELL_W'(1);
            cnt_q       <= '0;
            dir_up      <= 1'b1;
            second_leg  <= 1'b0;
            freq_word_q <= '0;
            word_upd_q  <= 1'b0;
            wave_sel_q  <= 4'b0001;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            word_upd_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;

            // Isolate the lowest set key bit: key 0 has the highest priority.
            if (bus.wave_key != 4'b0000)
                wave_sel_q <= bus.wave_key & (~bus.wave_key + 4'd1);

            if (state != S_IDLE && bus.abort) begin
                state  <= S_IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            if (bus.f_step == '0) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                mode_q      <= mode_e'(bus.mode);
                                f_start_q   <= bus.f_start;
                                f_stop_q    <= bus.f_stop;
                                f_step_q    <= bus.f_step;
                                dwell_q     <= dwell_eff;
                                cnt_q       <= dwell_eff - DWELL_W'(1);
                                dir_up      <= (bus.f_stop >= bus.f_start);
                                second_leg  <= 1'b0;
                                freq_word_q <= bus.f_start;
                                word_upd_q  <= 1'b1;
                                busy_q      <= 1'b1;
                                state       <= S_DWELL;
                            end
                        end
                    end

                    S_DWELL: begin
                        if (cnt_q == '0)
                            state <= S_STEP;
                        else
                            cnt_q <= cnt_q - DWELL_W'(1);
                    end

                    S_STEP: begin
                        state <= S_DWELL;
                        cnt_q <= dwell_q - DWELL_W'(1);
                        if (!at_target) begin
                            freq_word_q <= fwd_word;
                            word_upd_q  <= 1'b1;
                        end else begin
                            case (mode_q)
                                M_SINGLE: begin
                                    state  <= S_IDLE;
                                    busy_q <= 1'b0;
                                    done_q <= 1'b1;
                                end
                                M_ROUND: begin
                                    // Degenerate trip (start==stop) ends after the first leg.
                                    if (second_leg || freq_word_q == f_start_q) begin
                                        state  <= S_IDLE;
                                        busy_q <= 1'b0;
                                        done_q <= 1'b1;
                                    end else begin
                                        second_leg  <= 1'b1;
                                        dir_up      <= ~dir_up;
                                        freq_word_q <= rev_word;
                                        word_upd_q  <= (rev_word != freq_word_q);
                                    end
                                end
                                M_TRI: begin
                                    second_leg  <= ~second_leg;
                                    dir_up      <= ~dir_up;
                                    freq_word_q <= rev_word;
                                    word_upd_q  <= (rev_word != freq_word_q);
                                end
                                M_SAW: begin
                                    freq_word_q <= f_start_q;
                                    word_upd_q  <= (f_start_q != freq_word_q);
                                end
                                default: begin
                                    state  <= S_IDLE;
                                    busy_q <= 1'b0;
                                end
                            endcase
                        end
                    end

                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.freq_word = freq_word_q;
    assign bus.word_upd  = word_upd_q;
    assign bus.wave_sel  = wave_sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: cycle-exact word/update/busy/done traces
// against hand-computed sequences, plus config-error, abort and wave-select cases.
module tb_dds_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    dds_sweep_ctrl_if bus ();

    dds_sweep_ctrl dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] obs();
        return {bus.freq_word, bus.word_upd, bus.busy, bus.done};
    endfunction

    task automatic start_sweep(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                               input logic [31:0] fst, input logic [23:0] dw);
        bus.mode    = m;
        bus.f_start = fs;
        bus.f_stop  = fe;
        bus.f_step  = fst;
        bus.dwell   = dw;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic go_idle;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        logic [42:0] exp;
        exp = {32'd0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        n_assert++;
        if ({obs(), bus.wave_sel, bus.cfg_err, 1'b0} !== exp) begin
            n_fail++;
            $display("FAIL reset_values got %h exp %h", {obs(), bus.wave_sel, bus.cfg_err, 1'b0}, exp);
        end
    endtask

    task automatic test_single_up;
        logic [31:0] seq [4] = '{32'd100, 32'd110, 32'd120, 32'd130};
        logic [34:0] exp;
        start_sweep(2'b00, 32'd100, 32'd130, 32'd10, 24'd3);
        // Scrambled inputs while busy must not disturb the latched sweep.
        bus.f_start = 32'd7; bus.f_stop = 32'd9; bus.f_step = 32'd1; bus.dwell = 24'd0; bus.mode = 2'b10;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            exp = {(k < 16) ? seq[k/4] : 32'd130, (k < 16) && (k % 4 == 0), k < 16, k == 16};
            n_assert++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL single_up k=%0d got %h exp %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_single_saturate;
        logic [31:0] seq [4] = '{32'd100, 32'd110, 32'd120, 32'd125};
        logic [34:0] exp;
        start_sweep(2'b00, 32'd100, 32'd125, 32'd10, 24'd3);
        for (int k = 0; k < 19; k++) begin
            if (k > 0) tick();
            exp = {(k < 16) ? seq[k/4] : 32'd125, (k < 16) && (k % 4 == 0), k < 16, k == 16};
            n_assert++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL single_saturate k=%0d got %h exp %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_triangle_abort;
        logic [31:0] seq [7] = '{32'd50, 32'd35, 32'd20, 32'd35, 32'd50, 32'd35, 32'd20};
        logic [34:0] exp;
        start_sweep(2'b10, 32'd50, 32'd20, 32'd15, 24'd0);
        for (int k = 0; k < 14; k++) begin
            if (k > 0) tick();
            exp = {seq[k/2], k % 2 == 0, 1'b1, 1'b0};
            n_assert++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL triangle k=%0d got %h exp %h", k, obs(), exp);
            end
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            n_assert++;
            if (obs() !== {32'd20, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL triangle_abort k=%0d got %h exp %h", k, obs(), {32'd20, 3'b000});
            end
        end
    endtask

    task automatic test_round_trip;
        logic [31:0] seq [5] = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10};
        logic [34:0] exp;
        start_sweep(2'b01, 32'd10, 32'd30, 32'd10, 24'd0);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            exp = {seq[(k < 8) ? k/2 : 4], (k < 10) && (k % 2 == 0), k < 10, k == 10};
            n_assert++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL round_trip k=%0d got %h exp %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_sawtooth;
        logic [31:0] seq [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd0, 32'd10};
        logic [34:0] exp;
        start_sweep(2'b11, 32'd0, 32'd25, 32'd10, 24'd0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) tick();
            exp = {seq[k/2], k % 2 == 0, 1'b1, 1'b0};
            n_assert++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL sawtooth k=%0d got %h exp %h", k, obs(), exp);
            end
        end
        go_idle();
    endtask

    task automatic test_equal_endpoints;
        logic [34:0] exp;
        start_sweep(2'b10, 32'd77, 32'd77, 32'd5, 24'd1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            exp = {32'd77, k == 0, 1'b1, 1'b0};
            n_assert++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL equal_triangle k=%0d got %h exp %h", k, obs(), exp);
            end
        end
        go_idle();
        start_sweep(2'b00, 32'd55, 32'd55, 32'd5, 24'd0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            exp = {32'd55, k == 0, k < 2, k == 2};
            n_assert++;
            if (obs() !== exp) begin
                n_fail++;
                $display("FAIL equal_single k=%0d got %h exp %h", k, obs(), exp);
            end
        end
    endtask

    task automatic test_cfg_err;
        start_sweep(2'b00, 32'd55, 32'd55, 32'd5, 24'd0);
        tick(); tick(); tick();
        start_sweep(2'b00, 32'd300, 32'd400, 32'd0, 24'd2);
        n_assert++;
        if ({obs(), bus.cfg_err} !== {32'd55, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL cfg_err_pulse got %h exp %h", {obs(), bus.cfg_err}, {32'd55, 4'b0001});
        end
        tick();
        n_assert++;
        if ({obs(), bus.cfg_err} !== {32'd55, 4'b0000}) begin
            n_fail++;
            $display("FAIL cfg_err_clear got %h exp %h", {obs(), bus.cfg_err}, {32'd55, 4'b0000});
        end
        bus.abort = 1'b1;
        start_sweep(2'b00, 32'd300, 32'd400, 32'd10, 24'd2);
        bus.abort = 1'b0;
        n_assert++;
        if ({obs(), bus.cfg_err} !== {32'd55, 4'b0000}) begin
            n_fail++;
            $display("FAIL abort_with_start got %h exp %h", {obs(), bus.cfg_err}, {32'd55, 4'b0000});
        end
    endtask

    task automatic test_start_busy;
        start_sweep(2'b00, 32'd100, 32'd130, 32'd10, 24'd3);
        for (int k = 1; k <= 16; k++) begin
            bus.start   = (k == 6);
            bus.f_step  = 32'd0;
            bus.f_start = 32'd999;
            tick();
            if (k == 6 || k == 7) begin
                n_assert++;
                if ({obs(), bus.cfg_err} !== {32'd110, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                    n_fail++;
                    $display("FAIL start_busy k=%0d got %h exp %h", k, {obs(), bus.cfg_err}, {32'd110, 4'b0100});
                end
            end else if (k == 8 || k == 16) begin
                n_assert++;
                if (obs() !== {(k == 8) ? 32'd120 : 32'd130, k == 8, k == 8, k == 16}) begin
                    n_fail++;
                    $display("FAIL start_busy k=%0d got %h", k, obs());
                end
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_wave_key;
        logic [3:0] keys [5] = '{4'b0100, 4'b0110, 4'b0000, 4'b1000, 4'b1111};
        logic [3:0] sels [5] = '{4'b0100, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            bus.wave_key = keys[i];
            tick();
            bus.wave_key = 4'b0000;
            n_assert++;
            if (bus.wave_sel !== sels[i]) begin
                n_fail++;
                $display("FAIL wave_key key=%b got %b exp %b", keys[i], bus.wave_sel, sels[i]);
            end
        end
    endtask

    task automatic test_keys_mid_sweep;
        logic [31:0] seq [4] = '{32'd100, 32'd110, 32'd120, 32'd130};
        logic [38:0] exp;
        start_sweep(2'b00, 32'd100, 32'd130, 32'd10, 24'd3);
        for (int k = 0; k < 18; k++) begin
            if (k > 0) tick();
            bus.wave_key = (k == 1) ? 4'b1000 : (k == 9) ? 4'b0101 : 4'b0000;
            if (k >= 2) begin
                exp = {(k < 16) ? seq[k/4] : 32'd130, (k < 16) && (k % 4 == 0), k < 16, k == 16,
                       (k < 10) ? 4'b1000 : 4'b0001};
                n_assert++;
                if ({obs(), bus.wave_sel} !== exp) begin
                    n_fail++;
                    $display("FAIL keys_mid_sweep k=%0d got %h exp %h", k, {obs(), bus.wave_sel}, exp);
                end
            end
        end
        bus.wave_key = 4'b0000;
    endtask

    task automatic test_reset_mid_sweep;
        bus.wave_key = 4'b0100;
        start_sweep(2'b00, 32'd100, 32'd130, 32'd10, 24'd3);
        bus.wave_key = 4'b0000;
        tick(); tick(); tick(); tick(); tick();
        n_assert++;
        if (obs() !== {32'd110, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pre_reset_busy got %h", obs());
        end
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if ({obs(), bus.wave_sel, bus.cfg_err} !== {32'd0, 3'b000, 4'b0001, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_sweep got %h exp %h", {obs(), bus.wave_sel, bus.cfg_err}, {32'd0, 3'b000, 5'b00010});
        end
        #2 rst = 1'b0;
        tick(); tick();
        n_assert++;
        if ({obs(), bus.wave_sel} !== {32'd0, 3'b000, 4'b0001}) begin
            n_fail++;
            $display("FAIL post_reset_idle got %h", {obs(), bus.wave_sel});
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.mode     = 2'b00;
        bus.f_start  = '0;
        bus.f_stop   = '0;
        bus.f_step   = '0;
        bus.dwell    = '0;
        bus.wave_key = 4'b0000;
        #12;
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();

        test_single_up();
        test_single_saturate();
        test_triangle_abort();
        test_round_trip();
        test_sawtooth();
        test_equal_endpoints();
        test_cfg_err();
        test_start_busy();
        test_wave_key();
        test_keys_mid_sweep();
        test_reset_mid_sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
- Sequencing controller for the DDS datapath.
- Generates the frequency tuning word that drives the DDS phase accumulator and steps it through a programmable linear frequency sweep with a per-step dwell time.
- Also owns the registered one-hot waveform select that feeds the wave ROM, updated from debounced key pulses.
- Sits between the key/config logic and the DDS phase-accumulator/wave-control datapath.

Parameters:
FW_W, 32, frequency tuning word width
DWELL_W, 24, dwell counter width (cycles per step)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a sweep when idle
abort  in  1  level/pulse; terminates any sweep
mode  in  2  00 single up/down, 01 single round trip, 10 continuous triangle, 11 continuous sawtooth
f_start  in  FW_W  sweep start word
f_stop  in  FW_W  sweep end word
f_step  in  FW_W  increment per step, unsigned
dwell  in  DWELL_W  cycles each word is held; 0 treated as 1
wave_key  in  4  debounced one-cycle key pulses
freq_word  out  FW_W  tuning word to phase accumulator
word_upd  out  1  pulses the cycle freq_word changes
wave_sel  out  4  one-hot waveform select
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at natural sweep completion
cfg_err  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset values (async): freq_word=0, word_upd=0, wave_sel=4'b0001, busy=0, done=0, cfg_err=0, state IDLE.
- States: IDLE, DWELL, STEP.
- IDLE, start=1, f_step==0:
  - cfg_err=1 next cycle.
  - Stay IDLE; outputs otherwise unchanged.
- IDLE, start=1, f_step!=0:
  - Latch mode, f_start, f_stop, f_step and dwell (0 becomes 1).
  - Set dir=up if f_stop>=f_start, else down.
  - Next cycle: freq_word=f_start, word_upd=1, busy=1, dwell counter=dwell-1, state DWELL.
- DWELL: decrement counter; at 0 go to STEP.
- STEP (one cycle): compute next word, then return to DWELL with the counter reloaded. freq_word therefore changes every dwell+1 cycles, i.e. dwell cycles of DWELL plus one STEP cycle, and word_upd pulses in the cycle freq_word takes its new value.
- Next-word arithmetic:
  - Computed in FW_W+1 bits, so there is no wrap-around.
  - up: next = min(cur+f_step, target). down: next = max(cur-f_step, target).
  - The endpoint is always reached exactly (saturated); the last step may be smaller than f_step.
- Endpoint handling, when cur==target on entering STEP:
  - mode 00: go IDLE; done=1 one cycle; busy=0; freq_word held (no word_upd).
  - mode 01 first leg: reverse dir, target=f_start, step normally.
  - mode 01 second leg: done as for mode 00.
  - mode 10: reverse dir and swap target; continues until abort.
  - mode 11: freq_word=f_start with word_upd; same dir; continues until abort.
- f_start==f_stop:
  - Modes 00/01: one dwell at f_start, then done.
  - Modes 10/11: word held constant, no further word_upd, busy stays 1 until abort.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, busy=0, no done, freq_word held.
  - abort with start in the same IDLE cycle: start ignored.
- start while busy: ignored; no cfg_err.
- Config input changes while busy have no effect (values latched at start).
- wave_key handling:
  - Any nonzero wave_key updates wave_sel next cycle, in any state.
  - Lowest set bit wins (key 0 highest priority); wave_sel always one-hot.
  - wave_key=0: no change. Independent of the sweep, and never resets the sweep.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-sweep: immediate return to reset values.

Test Plan:
- Reset mid-sweep (sys_rst pulsed while busy=1) -> all outputs immediately at reset values; freq_word=0; wave_sel=0001.
- mode=00, f_start=100, f_stop=130, f_step=10, dwell=3:
  - freq_word sequence 100,110,120,130, one word every 4 cycles, 4 word_upd pulses total.
  - done pulses 4 cycles after 130 is loaded; busy=0 after.
- mode=00, f_start=100, f_stop=125, f_step=10 -> words 100,110,120,125 (saturated last step); then done.
- mode=10, f_start=50, f_stop=20, f_step=15, dwell=0:
  - Words 50,35,20,35,50,35,…, changing every 2 cycles.
  - Assert abort -> busy=0 next cycle, word held, done never pulses.
- start with f_step=0 -> cfg_err one pulse, busy stays 0, freq_word unchanged. Also: start while busy is ignored.
- wave_key sequence:
  - 0100 -> wave_sel=0100; then 0110 -> 0010; then 0000 -> stays 0010.
  - Pressing keys mid-sweep leaves the freq_word sequence unchanged.
